// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/opcode handshake in, flagged result handshake out
interface alu_pipe_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       alu_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic             z;
   logic             c;
   logic             o;
   logic             n;
   logic             err;
   modport master (
      output in_valid, a, b, alu_sel, out_ready,
      input  in_ready, out_valid, alu_out, z, c, o, n, err
   );
   modport slave (
      input  in_valid, a, b, alu_sel, out_ready,
      output in_ready, out_valid, alu_out, z, c, o, n, err
   );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU with registered result; define ALU_MUL_EN to build the iterative multiplier for opcode 1111
module alu_pipe #(parameter int WIDTH = 8) (
   input logic       clk,
   input logic       rst_n,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   logic [WIDTH-1:0] a, b, alu_out, r_val;
   logic [WIDTH:0]   ext;
   logic             ovf, ill, free, accept, ld, r_c, r_o, r_err;
   logic             out_valid, z, c, o, n, err;
   assign a = bus.a;
   assign b = bus.b;
   assign free = !out_valid || bus.out_ready;
   assign accept = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid;
   assign bus.alu_out = alu_out;
   assign bus.z = z;
   assign bus.c = c;
   assign bus.o = o;
   assign bus.n = n;
   assign bus.err = err;
   // single-cycle datapath: result in ext[WIDTH-1:0], carry/borrow/shifted-out bit in ext[WIDTH]
   always_comb begin
      ext = '0;
      ovf = 1'b0;
      ill = 1'b0;
      case (bus.alu_sel)
         4'h0: begin
            ext = {1'b0, a} + {1'b0, b};
            ovf = (a[WIDTH-1] ~^ b[WIDTH-1]) & (a[WIDTH-1] ^ ext[WIDTH-1]);
         end
         4'h1: begin
            ext = {1'b0, a} - {1'b0, b};
            ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ ext[WIDTH-1]);
         end
         4'h2: ext = {1'b0, a & b};
         4'h3: ext = {1'b0, a | b};
         4'h4: ext = {1'b0, a ^ b};
         4'h5: ext = {1'b0, ~a};
         4'h6: ext = {a, 1'b0};
         4'h7: ext = {a[0], 1'b0, a[WIDTH-1:1]};
         4'h8: ext = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
         4'h9: ext = {1'b0, a} + (WIDTH+1)'(1);
         4'hA: ext = {1'b0, a} - (WIDTH+1)'(1);
         4'hB: ext = {1'b0, (a == b) ? WIDTH'(1) : (a > b) ? WIDTH'(2) : WIDTH'(4)};
         4'hC: ext = {1'b0, a};
         4'hD: ext = {1'b0, b};
         4'hE: ext = {1'b0, a} << b[SHW-1:0];
         default: ill = 1'b1;
      endcase
   end
`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
   state_t             state, state_nx;
   logic [SHW-1:0]     cnt;
   logic [2*WIDTH-1:0] acc, mcand, acc_nx, prod;
   logic [WIDTH-1:0]   mplier;
   logic               start, load_alu, load_mul;
   assign acc_nx = acc + (mplier[0] ? mcand : '0);
   assign prod = (state == HOLD) ? acc : acc_nx;
   assign bus.in_ready = (state == IDLE) && free;
   assign ld = load_alu || load_mul;
   assign r_val = load_mul ? prod[WIDTH-1:0] : ext[WIDTH-1:0];
   assign r_c = load_mul ? |prod[2*WIDTH-1:WIDTH] : ext[WIDTH];
   assign r_o = !load_mul && ovf;
   assign r_err = !load_mul && ill;
   // state register; reset aborts any multiply in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   end
   // next state and load strobes; a finished product waits in HOLD while the result register is full
   always_comb begin
      state_nx = state;
      start = 1'b0;
      load_alu = 1'b0;
      load_mul = 1'b0;
      case (state)
         IDLE: if (accept) begin
            start = bus.alu_sel == 4'hF;
            load_alu = !start;
            state_nx = start ? MUL : IDLE;
         end
         MUL: if (cnt == '0) begin
            load_mul = free;
            state_nx = free ? IDLE : HOLD;
         end
         HOLD: begin
            load_mul = free;
            state_nx = free ? IDLE : HOLD;
         end
         default: state_nx = IDLE;
      endcase
   end
   // shift-add multiplier: one partial product per cycle, counter runs WIDTH-1 down to 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         acc <= '0;
         mcand <= '0;
         mplier <= '0;
      end else if (start) begin
         cnt <= SHW'(WIDTH - 1);
         acc <= '0;
         mcand <= {{WIDTH{1'b0}}, a};
         mplier <= b;
      end else if (state == MUL) begin
         cnt <= cnt - SHW'(cnt != '0);
         acc <= acc_nx;
         mcand <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end
`else
   assign bus.in_ready = free;
   assign ld = accept;
   assign r_val = ext[WIDTH-1:0];
   assign r_c = ext[WIDTH];
   assign r_o = ovf;
   assign r_err = ill;
`endif
   // result register: loads a new result (even while the old one is consumed), otherwise empties on consume
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         alu_out <= '0;
         z <= 1'b0;
         c <= 1'b0;
         o <= 1'b0;
         n <= 1'b0;
         err <= 1'b0;
      end else if (ld) begin
         out_valid <= 1'b1;
         alu_out <= r_val;
         z <= r_val == '0;
         c <= r_c;
         o <= r_o;
         n <= r_val[WIDTH-1];
         err <= r_err;
      end else if (bus.out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule
